reg_rename: RTL and testbench

//  Register-rename stage upstream of the 64-entry physical register file. Maps the decoded

---
 rtl/reg_rename.sv | 101 ++++++++++
 tb/tb_reg_rename.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_rename.sv
// reg_rename: speculative/committed register maps with a free-list bitmap for a 64-entry PRF
module reg_rename #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int ARCH_W    = $clog2(ARCH_REGS),
    parameter int PHYS_W    = $clog2(PHYS_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_ren_valid,
    input  logic [ARCH_W-1:0] i_ren_rs_arch,
    input  logic [ARCH_W-1:0] i_ren_rt_arch,
    input  logic              i_ren_uses_rw,
    input  logic [ARCH_W-1:0] i_ren_rw_arch,
    output logic              o_ren_ready,
    output logic [PHYS_W-1:0] o_rs_phy,
    output logic [PHYS_W-1:0] o_rt_phy,
    output logic [PHYS_W-1:0] o_rw_phy,
    output logic [PHYS_W-1:0] o_rw_old_phy,
    input  logic              i_commit_valid,
    input  logic              i_commit_uses_rw,
    input  logic [ARCH_W-1:0] i_commit_rw_arch,
    input  logic [PHYS_W-1:0] i_commit_rw_phy,
    input  logic [PHYS_W-1:0] i_commit_old_phy,
    input  logic              i_flush,
    output logic [PHYS_W:0]   o_free_count
);
    logic [PHYS_W-1:0]    r_spec_map   [ARCH_REGS];
    logic [PHYS_W-1:0]    r_retire_map [ARCH_REGS];
    logic [PHYS_REGS-1:0] r_free;
    logic [PHYS_W:0]      r_free_count;
    logic [PHYS_W-1:0]    w_retire_next [ARCH_REGS];
    logic [PHYS_REGS-1:0] w_mapped;
    logic [PHYS_REGS-1:0] w_free_next;
    logic [PHYS_REGS-1:0] w_flush_free;
    logic [PHYS_W-1:0]    w_alloc;
    logic                 w_need_alloc;
    logic                 w_alloc_en;
    logic                 w_commit;
    logic                 w_free_inc;

    assign w_need_alloc = i_ren_uses_rw && (i_ren_rw_arch != '0);
    assign o_ren_ready  = !i_flush && (!w_need_alloc || (r_free_count != '0));
    assign w_alloc_en   = i_ren_valid && o_ren_ready && w_need_alloc;
    assign w_commit     = i_commit_valid && i_commit_uses_rw && (i_commit_rw_arch != '0);
    assign w_free_inc   = w_commit && (i_commit_old_phy != '0);
    assign o_rs_phy     = (i_ren_rs_arch == '0) ? '0 : r_spec_map[i_ren_rs_arch];
    assign o_rt_phy     = (i_ren_rt_arch == '0) ? '0 : r_spec_map[i_ren_rt_arch];
    assign o_rw_phy     = w_need_alloc ? w_alloc : '0;
    assign o_rw_old_phy = w_need_alloc ? r_spec_map[i_ren_rw_arch] : '0;
    assign o_free_count = r_free_count;
    assign w_flush_free = ~w_mapped & ~PHYS_REGS'(1);

    // Lowest-index free tag; a tag freed by this cycle's commit is not yet visible here
    always_comb begin
        w_alloc = '0;
        for (int p = PHYS_REGS - 1; p >= 0; p--)
            if (r_free[p]) w_alloc = PHYS_W'(p);
    end

    // Committed map after this cycle's commit, and which tags it still references
    always_comb begin
        w_retire_next = r_retire_map;
        if (w_commit) w_retire_next[i_commit_rw_arch] = i_commit_rw_phy;
        w_mapped = '0;
        for (int a = 0; a < ARCH_REGS; a++) w_mapped[w_retire_next[a]] = 1'b1;
    end

    // Free list for the non-flush case: allocation clears, commit returns the old tag
    always_comb begin
        w_free_next = r_free;
        if (w_alloc_en) w_free_next[w_alloc] = 1'b0;
        if (w_free_inc) w_free_next[i_commit_old_phy] = 1'b1;
    end

    // State update; flush rebuilds speculative state from the just-updated committed map
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                r_spec_map[i]   <= PHYS_W'(i);
                r_retire_map[i] <= PHYS_W'(i);
            end
            r_free       <= {{(PHYS_REGS - ARCH_REGS){1'b1}}, {ARCH_REGS{1'b0}}};
            r_free_count <= (PHYS_W + 1)'(PHYS_REGS - ARCH_REGS);
        end else begin
            r_retire_map <= w_retire_next;
            if (i_flush) begin
                r_spec_map   <= w_retire_next;
                r_free       <= w_flush_free;
                r_free_count <= (PHYS_W + 1)'($countones(w_flush_free));
            end else begin
                if (w_alloc_en) r_spec_map[i_ren_rw_arch] <= w_alloc;
                r_free       <= w_free_next;
                r_free_count <= r_free_count + (PHYS_W + 1)'(w_free_inc) - (PHYS_W + 1)'(w_alloc_en);
            end
        end
    end

    a_double_free: assert property (@(posedge clk) disable iff (rst)
        w_free_inc |-> !r_free[i_commit_old_phy]);
endmodule

// File: tb/tb_reg_rename.sv
// tb_reg_rename: directed rename/commit/flush vectors checked against a map-and-set model
module tb_reg_rename;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid, uses, cv, cu, fl;
    logic [4:0] rs, rt, rw, ca;
    logic [5:0] cp, co;
    logic       ready;
    logic [5:0] rsp, rtp, rwp, oldp;
    logic [6:0] fc;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         m_spec [32];
    int         m_ret  [32];
    bit         m_free [64];

    typedef struct { logic [4:0] a; logic [5:0] p; logic [5:0] o; } ren_t;
    ren_t rob [$];

    reg_rename dut (
        .clk(clk), .rst(rst),
        .i_ren_valid(valid), .i_ren_rs_arch(rs), .i_ren_rt_arch(rt),
        .i_ren_uses_rw(uses), .i_ren_rw_arch(rw), .o_ren_ready(ready),
        .o_rs_phy(rsp), .o_rt_phy(rtp), .o_rw_phy(rwp), .o_rw_old_phy(oldp),
        .i_commit_valid(cv), .i_commit_uses_rw(cu), .i_commit_rw_arch(ca),
        .i_commit_rw_phy(cp), .i_commit_old_phy(co), .i_flush(fl), .o_free_count(fc)
    );

    initial forever #5 clk = ~clk;

    function automatic int m_nfree();
        int n = 0;
        for (int p = 0; p < 64; p++) n += int'(m_free[p]);
        return n;
    endfunction

    function automatic int m_lowest();
        for (int p = 0; p < 64; p++) if (m_free[p]) return p;
        return 0;
    endfunction

    function automatic bit m_need();
        return uses && rw != 0;
    endfunction

    function automatic bit m_ready();
        return !fl && (!m_need() || m_nfree() > 0);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: maps as plain arrays, free tags as a set; updated on each edge or reset
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            for (int i = 0; i < 32; i++) begin m_spec[i] = i; m_ret[i] = i; end
            for (int p = 0; p < 64; p++) m_free[p] = (p >= 32);
        end else begin
            int a;
            bit fire;
            a = m_lowest();
            fire = valid && m_ready();
            if (fire && m_need()) begin m_spec[rw] = a; m_free[a] = 0; end
            if (cv && cu && ca != 0) begin
                m_ret[ca] = int'(cp);
                if (co != 0) m_free[co] = 1;
            end
            if (fl) begin
                for (int p = 0; p < 64; p++) m_free[p] = 1;
                for (int i = 0; i < 32; i++) begin m_spec[i] = m_ret[i]; m_free[m_ret[i]] = 0; end
                m_free[0] = 0;
            end
        end
    end

    // Every-cycle comparison of all meaningful outputs against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("ready", int'(ready), int'(m_ready()));
            chk("free_count", int'(fc), m_nfree());
            if (valid) begin
                chk("rs_phy", int'(rsp), rs == 0 ? 0 : m_spec[rs]);
                chk("rt_phy", int'(rtp), rt == 0 ? 0 : m_spec[rt]);
                chk("rw_phy", int'(rwp), m_need() ? m_lowest() : 0);
                chk("rw_old_phy", int'(oldp), m_need() ? m_spec[rw] : 0);
            end
        end
    end

    task automatic idle();
        valid = 0; uses = 0; cv = 0; cu = 0; fl = 0;
        rs = 0; rt = 0; rw = 0; ca = 0; cp = 0; co = 0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic do_reset();
        rst = 1;
        idle();
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        idle();
        do_reset();
        // reset state lookups
        valid = 1; rs = 5; rt = 0;
        settle();
        chk("t1_rs", int'(rsp), 5); chk("t1_rt", int'(rtp), 0);
        chk("t1_fc", int'(fc), 32); chk("t1_ready", int'(ready), 1);
        step();
        // first allocation; source sees pre-rename mapping
        valid = 1; uses = 1; rw = 3; rs = 3;
        settle();
        chk("t2_rw", int'(rwp), 32); chk("t2_old", int'(oldp), 3); chk("t2_rs_old", int'(rsp), 3);
        step();
        valid = 1; rs = 3;
        settle();
        chk("t2_rs_new", int'(rsp), 32); chk("t2_fc", int'(fc), 31);
        step();
        // asynchronous reset mid-cycle
        valid = 1; rs = 3;
        #2 rst = 1;
        #1;
        chk("t6_rs", int'(rsp), 3); chk("t6_fc", int'(fc), 32);
        @(posedge clk);
        #1 rst = 0;
        idle();
        // exhaust the free list
        for (int i = 0; i < 32; i++) begin
            valid = 1; uses = 1; rw = 1;
            settle();
            chk("t3_rw", int'(rwp), 32 + i);
            step();
        end
        valid = 1; uses = 1; rw = 1;
        settle();
        chk("t3_fc", int'(fc), 0); chk("t3_ready_full", int'(ready), 0);
        rw = 0;
        #1 chk("t3_ready_r0", int'(ready), 1);
        step();
        // freed tag not allocatable in the same cycle
        valid = 1; uses = 1; rw = 1;
        cv = 1; cu = 1; ca = 1; cp = 32; co = 1;
        settle();
        chk("t4_ready_same", int'(ready), 0);
        step();
        valid = 1; uses = 1; rw = 1;
        settle();
        chk("t4_fc", int'(fc), 1); chk("t4_rw", int'(rwp), 1); chk("t4_old", int'(oldp), 63);
        step();
        // flush with same-cycle commit
        do_reset();
        for (int i = 0; i < 3; i++) begin
            valid = 1; uses = 1; rw = (i == 2) ? 5'd4 : 5'(i + 1);
            settle();
            chk("t5_alloc", int'(rwp), 32 + i);
            step();
        end
        valid = 1; uses = 1; rw = 6; fl = 1;
        cv = 1; cu = 1; ca = 1; cp = 32; co = 1;
        settle();
        chk("t5_ready_flush", int'(ready), 0);
        step();
        valid = 1; uses = 1; rw = 5; rs = 1; rt = 2;
        settle();
        chk("t5_r1", int'(rsp), 32); chk("t5_r2", int'(rtp), 2);
        chk("t5_fc", int'(fc), 32); chk("t5_rw", int'(rwp), 1);
        rs = 4;
        #1 chk("t5_r4", int'(rsp), 4);
        step();
        // mixed renames and in-order commits, then flush
        for (int i = 0; i < 24; i++) begin
            valid = 1; uses = 1; rw = 5'((i % 7) + 1);
            rs = 5'((i * 3) % 32); rt = 5'((i * 5) % 32);
            if (m_ready()) rob.push_back('{rw, 6'(m_lowest()), 6'(m_spec[rw])});
            if ((i % 2) == 1 && rob.size() > 1) begin
                ren_t h;
                h = rob.pop_front();
                cv = 1; cu = 1; ca = h.a; cp = h.p; co = h.o;
            end
            step();
        end
        fl = 1;
        step();
        rob.delete();
        valid = 1; uses = 1; rw = 7; rs = 7;
        step();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
